// File: rtl/data_read_axi_write.sv
// AXI-lite write-channel slave for the data_read core: decodes CR/SR writes, drives capture strobes, returns B.
// Define DATA_READ_BUF_WR_EN to let buffer-region writes reach the capture buffers.
`ifndef AXI_ADDR_CR
`define AXI_ADDR_CR 32'h0000_0000
`endif
`ifndef AXI_ADDR_SR
`define AXI_ADDR_SR 32'h0000_0004
`endif

module data_read_axi_write #(
    parameter logic [31:0] C_CR_RESET = 32'h0000_0000,
    parameter int unsigned C_BUF_AW   = 10
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESET,
    input  logic [31:0]         S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [31:0]         S_AXI_WDATA,
    input  logic [3:0]          S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    output logic [31:0]         cr_q,
    output logic                cr_en,
    output logic                cr_start,
    output logic                sr_c_clr,
    output logic                buf_wr_en,
    output logic [1:0]          buf_wr_sel,
    output logic [C_BUF_AW-1:0] buf_wr_addr,
    output logic [31:0]         buf_wr_data
);

    typedef enum logic [2:0] {IDLE, HAVE_A, HAVE_W, EXEC, RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    logic        aw_hs;
    logic        w_hs;
    logic        hit_cr;
    logic        hit_sr;
    logic        hit_buf;
    logic [31:0] cr_d;

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID && wready_q;

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign cr_en         = cr_q[0];

    // NOTE: every variable below is assigned on every path through the block, so no latch is inferred.
    always_comb begin
        hit_cr  = (awaddr_q == `AXI_ADDR_CR);
        hit_sr  = (awaddr_q == `AXI_ADDR_SR);
        hit_buf = !hit_cr && !hit_sr && (awaddr_q[12:10] >= 3'd1) && (awaddr_q[12:10] <= 3'd4);
        for (int i = 0; i < 4; i++) begin
            cr_d[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : cr_q[8*i +: 8];
        end
        // CR[1] is the start request; it only ever exists as the cr_start pulse.
        cr_d[1] = 1'b0;
    end

    // NOTE: non-blocking assignments so every register here samples the values from before the edge.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            cr_q        <= C_CR_RESET;
            cr_start    <= 1'b0;
            sr_c_clr    <= 1'b0;
            buf_wr_en   <= 1'b0;
            buf_wr_sel  <= '0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
        end else begin
            cr_start  <= 1'b0;
            sr_c_clr  <= 1'b0;
            buf_wr_en <= 1'b0;
            case (state_q)
                IDLE: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (aw_hs) awaddr_q <= S_AXI_AWADDR;
                    if (w_hs) begin
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                    end
                    if (aw_hs && w_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        state_q   <= EXEC;
                    end else if (aw_hs) begin
                        awready_q <= 1'b0;
                        state_q   <= HAVE_A;
                    end else if (w_hs) begin
                        wready_q  <= 1'b0;
                        state_q   <= HAVE_W;
                    end
                end
                HAVE_A: begin
                    if (w_hs) begin
                        wdata_q  <= S_AXI_WDATA;
                        wstrb_q  <= S_AXI_WSTRB;
                        wready_q <= 1'b0;
                        state_q  <= EXEC;
                    end
                end
                HAVE_W: begin
                    if (aw_hs) begin
                        awaddr_q  <= S_AXI_AWADDR;
                        awready_q <= 1'b0;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    state_q <= RESP;
                    bresp_q <= RESP_OKAY;
                    // An all-zero strobe is a harmless no-op wherever it lands.
                    if (wstrb_q != 4'b0000) begin
                        if (hit_cr) begin
                            cr_q     <= cr_d;
                            cr_start <= wdata_q[1] && wstrb_q[0];
                        end else if (hit_sr) begin
                            sr_c_clr <= wdata_q[0] && wstrb_q[0];
                        end else if (hit_buf) begin
`ifdef DATA_READ_BUF_WR_EN
                            buf_wr_en   <= 1'b1;
                            buf_wr_sel  <= awaddr_q[11:10] - 2'd1;
                            buf_wr_addr <= awaddr_q[C_BUF_AW-1:0];
                            buf_wr_data <= wdata_q;
`else
                            bresp_q <= RESP_SLVERR;
`endif
                        end else begin
                            bresp_q <= RESP_SLVERR;
                        end
                    end
                end
                RESP: begin
                    // First RESP cycle raises BVALID; it then holds until the master takes it.
                    if (!bvalid_q) begin
                        bvalid_q <= 1'b1;
                    end else if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        awaddr_q  <= '0;
                        wdata_q   <= '0;
                        wstrb_q   <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
